psum_drain_serializer: RTL
==========================

// Module: psum_drain_serializer
// PURPOSE
//  Read side of the PE accumulation path. Takes one snapshot of the N_ROWS
//  partial sums (o_c outputs of adder_generic) from a systolic-array column.
//  Streams the snapshot out one word per beat over a valid/ready interface.
//  Each word is signed-saturated from OC_W to OUT_W bits.
//  Sits between the array column and the output SRAM write path.
// PARAMETERS
//  OC_W    16  width of each accumulated partial sum (signed, 2's complement)
//  OUT_W   16  width of each emitted word (signed); OUT_W >= 2
//  N_ROWS  8   number of partial sums per snapshot; N_ROWS >= 2
//  IDX_W   $clog2(N_ROWS)  derived local param, width of o_idx
// PORTS
//  i_clk        in   1              clock, rising edge
//  i_rst        in   1              synchronous reset, active-high
//  i_cap_valid  in   1              snapshot on i_psums is valid
//  o_cap_ready  out  1              block can accept a snapshot this cycle
//  i_psums      in   N_ROWS*OC_W    packed sums; word k = i_psums[k*OC_W +: OC_W]
//  o_valid      out  1              o_data/o_idx/o_last/o_sat hold a valid beat
//  i_ready      in   1              downstream accepts the beat
//  o_data       out  OUT_W          saturated partial sum
//  o_idx        out  IDX_W          row index of current beat
//  o_last       out  1              current beat is row N_ROWS-1
//  o_sat        out  1              current beat was clamped
// BEHAVIOUR
//  - FSM: IDLE, SHIFT. Registers: buf[N_ROWS] (OC_W each), cnt (IDX_W).
//  - Reset (sync, i_rst=1 at edge): state=IDLE, cnt=0, buf=0.
//    Output reset values: o_valid=0, o_cap_ready=1, o_data=0, o_idx=0,
//    o_last=0, o_sat=0. Reset in SHIFT discards the remaining beats.
//  - Capture handshake: i_cap_valid & o_cap_ready at an edge.
//    On capture: buf <= i_psums, cnt <= 0, state <= SHIFT.
//  - o_cap_ready = (state==IDLE) | (state==SHIFT & o_last & i_ready).
//    This path is combinational from i_ready; it gives back-to-back
//    snapshots with no bubble.
//  - o_cap_ready depends on i_ready only; it never depends on i_cap_valid.
//  - IDLE: o_valid=0; o_data/o_idx/o_last/o_sat driven 0.
//  - SHIFT: o_valid=1, o_idx=cnt, o_data=sat(buf[cnt]), o_last=(cnt==N_ROWS-1).
//    Beat transfer: o_valid & i_ready.
//    On transfer, not last: cnt <= cnt+1.
//    On transfer, last: if capture in the same cycle, load a new snapshot,
//    cnt <= 0, stay SHIFT; otherwise state <= IDLE, cnt <= 0.
//    No transfer: all outputs held stable (AXI-stream style); no beat skipped.
//  - Capture attempts in SHIFT outside the last-beat-accepted cycle see
//    o_cap_ready=0 and are ignored; buf is not modified.
//  - Latency: capture at edge t -> first beat (idx 0) valid in cycle t+1.
//    One snapshot takes N_ROWS beats at minimum.
//  - Saturation, signed:
//    If OUT_W >= OC_W: sign-extend, o_sat=0.
//    Else: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    o_sat=1 iff the value was out of that range.
//  - Emission order is always row 0 first, up to row N_ROWS-1.
// TESTING  (OC_W=16, OUT_W=8, N_ROWS=4 unless stated)
//  1. Basic drain: capture words {0x0003, 0xFFFE, 0x0100, 0xFF00}, i_ready=1.
//     Required beats: 0x03/sat0, 0xFE/sat0, 0x7F/sat1, 0x80/sat1.
//     o_last=1 only on beat 3; IDLE on the next cycle.
//  2. Backpressure: i_ready=0 for 3 cycles while idx=1 is presented.
//     Required: o_data=0xFE and o_idx=1 stable for those cycles, then 0x7F, then 0x80.
//  3. Back-to-back: i_cap_valid=1 during the last beat with i_ready=1.
//     Required: next cycle o_valid=1, o_idx=0, o_data from the new snapshot; no idle cycle.
//  4. Illegal capture: i_cap_valid=1 during beats 0-2.
//     Required: o_cap_ready=0, the current stream is unchanged, 4 beats emitted.
//  5. Reset mid-stream: i_rst=1 while idx=2.
//     Required: next cycle o_valid=0, o_cap_ready=1, o_data=0.
//     A new capture streams from idx 0.
//  6. OUT_W=16: capture {0x8000, 0x7FFF, 0x0000, 0x1234}.
//     Required: exact pass-through, o_sat=0 on all beats.

Source files
------------

// File: rtl/psum_drain_serializer_if.sv
// Capture and drain handshake bundle for the partial-sum serializer.
// The slave side is the serializer; the master side is its environment.
interface psum_drain_serializer_if #(
  parameter int OC_W   = 16,
  parameter int OUT_W  = 16,
  parameter int N_ROWS = 8
);
  localparam int IDX_W = $clog2(N_ROWS);

  logic                     i_cap_valid;
  logic                     o_cap_ready;
  logic [N_ROWS*OC_W-1:0]   i_psums;
  logic                     o_valid;
  logic                     i_ready;
  logic [OUT_W-1:0]         o_data;
  logic [IDX_W-1:0]         o_idx;
  logic                     o_last;
  logic                     o_sat;

  modport slave (
    input  i_cap_valid,
    input  i_psums,
    input  i_ready,
    output o_cap_ready,
    output o_valid,
    output o_data,
    output o_idx,
    output o_last,
    output o_sat
  );

  modport master (
    output i_cap_valid,
    output i_psums,
    output i_ready,
    input  o_cap_ready,
    input  o_valid,
    input  o_data,
    input  o_idx,
    input  o_last,
    input  o_sat
  );
endinterface

// File: rtl/psum_drain_serializer.sv
// Snapshots one column of partial sums and streams them out row by row,
// signed-saturating each word from OC_W to OUT_W bits.
module psum_drain_serializer #(
  parameter int OC_W   = 16,
  parameter int OUT_W  = 16,
  parameter int N_ROWS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  psum_drain_serializer_if.slave bus
);
  localparam int IDX_W = $clog2(N_ROWS);
  localparam int W     = (OUT_W > OC_W) ? OUT_W : OC_W;

  localparam logic signed [W-1:0] MAXV =
    W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [W-1:0] MINV = ~MAXV;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ROWS-1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [OC_W-1:0]  snap [N_ROWS];
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_nxt;
  logic             xfer;
  logic             cap;
  logic [OUT_W:0]   sat0;
  logic [OUT_W:0]   satn;

  // MSB of the result is the clamp flag, the rest is the emitted word.
  function automatic logic [OUT_W:0] sat(
    input logic [OC_W-1:0] v
  );
    logic signed [W-1:0] x;
    x = W'(signed'(v));
    if (x > MAXV)
      sat = {1'b1, MAXV[OUT_W-1:0]};
    else if (x < MINV)
      sat = {1'b1, MINV[OUT_W-1:0]};
    else
      sat = {1'b0, x[OUT_W-1:0]};
  endfunction

  // Ready is combinational on i_ready so a new
  // snapshot can land on the last accepted beat.
  assign bus.o_cap_ready =
    (state == IDLE) |
    ((state == SHIFT) & bus.o_last & bus.i_ready);

  assign xfer    = bus.o_valid & bus.i_ready;
  assign cap     = bus.i_cap_valid & bus.o_cap_ready;
  assign cnt_nxt = cnt + ONE;

  always_comb begin
    sat0 = sat(bus.i_psums[0 +: OC_W]);
    satn = '0;
    if (cnt != LAST_IDX)
      satn = sat(snap[cnt_nxt]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      for (int k = 0; k < N_ROWS; k++)
        snap[k] <= '0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_idx   <= '0;
      bus.o_last  <= 1'b0;
      bus.o_sat   <= 1'b0;
    end else begin
      priority case (1'b1)
        cap: begin
          for (int k = 0; k < N_ROWS; k++)
            snap[k] <= bus.i_psums[k*OC_W +: OC_W];
          state       <= SHIFT;
          cnt         <= '0;
          bus.o_valid <= 1'b1;
          bus.o_idx   <= '0;
          bus.o_data  <= sat0[OUT_W-1:0];
          bus.o_sat   <= sat0[OUT_W];
          bus.o_last  <= 1'b0;
        end
        (xfer & ~bus.o_last): begin
          cnt         <= cnt_nxt;
          bus.o_idx   <= cnt_nxt;
          bus.o_data  <= satn[OUT_W-1:0];
          bus.o_sat   <= satn[OUT_W];
          bus.o_last  <= (cnt_nxt == LAST_IDX);
        end
        xfer: begin
          state       <= IDLE;
          cnt         <= '0;
          bus.o_valid <= 1'b0;
          bus.o_data  <= '0;
          bus.o_idx   <= '0;
          bus.o_last  <= 1'b0;
          bus.o_sat   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
